sccb_master: RTL and testbench
==============================

# sccb_master

Serial Camera Control Bus (SCCB) write master for the OV7670. It sits directly downstream of the camera configuration sequencer and turns each `start` + register address + register data request into one 3-phase SCCB write on SIOC/SIOD. Only writes are supported. `ready` is the flow-control handshake back to the sequencer. The lines are driven open-drain through active-high pull-low enables, and the top level owns the pads.

## Interface
- `CLK_FREQ`, 25000000, system clock frequency in Hz
- `SCCB_FREQ`, 100000, SIOC frequency in Hz
- `CAMERA_ADDR`, 8'h42, OV7670 write ID, sent as phase-1 byte

- `clk`  in  1  system clock; the only clock in the block
- `reset`  in  1  reset, synchronous and active-high
- `start`  in  1  request; accepted only on a cycle where `ready`=1
- `address`  in  8  register address, captured on accept
- `data`  in  8  register data, captured on accept
- `ready`  out  1  1 = idle and able to accept a request
- `sioc_oe`  out  1  1 = pull SIOC low; 0 = release (pulled high)
- `siod_oe`  out  1  1 = pull SIOD low; 0 = release (pulled high)

## Operation
- Reset values: `ready`=1, `sioc_oe`=0, `siod_oe`=0, state IDLE, divider cleared.
- Quarter period Q = CLK_FREQ/(4*SCCB_FREQ), integer floor. With defaults Q=62.
  - Q<2 is an elaboration error.
- A quarter tick fires every Q cycles. The divider restarts on accept, so the first tick comes Q cycles after accept.
- Accept condition: `start`=1 and `ready`=1 at a rising edge.
  - The block latches `{CAMERA_ADDR, address, data}` into a 24-bit shift register.
  - `ready` goes to 0 on the next cycle.
  - `start` while `ready`=0 is ignored and has no queueing.
- States; every transition happens on a quarter tick:
  - IDLE: both lines released.
  - START1 (1Q): `siod_oe`=1, SIOC high.
  - START2 (1Q): `sioc_oe`=1.
  - BIT_LO (2Q): `sioc_oe`=1; SIOD is set on state entry.
  - BIT_HI (2Q): `sioc_oe`=0; SIOD is held.
  - STOP1 (1Q): `sioc_oe`=1, `siod_oe`=1.
  - STOP2 (1Q): `sioc_oe`=0.
  - STOP3 (1Q): `siod_oe`=0.
  - Then IDLE.
- Bit slots: 27 total, being 3 phases × 9 bits, sent MSB first.
  - Data bits drive `siod_oe` = ~bit.
  - The 9th bit of each phase is don't-care: `siod_oe`=0 and SIOD is not sampled.
- A 5-bit bit counter (0..8) and a 2-bit phase counter sequence the slots. After phase 2 bit 8, the FSM goes to STOP1.
- SIOD changes only while SIOC is low, with two exceptions:
  - the START1 falling edge;
  - the STOP3 rising edge.
- Reset mid-transaction: lines are released and `ready`=1 on the first edge with `reset`=1. No stop condition is generated; the camera recovers on the next start.

## Timing
- One transaction is 2 + 27×4 + 3 = 113 quarters.
- `ready` is low for exactly 113×Q cycles, starting the cycle after accept. With defaults this is 7006 cycles.
- `ready` rises in the same cycle that STOP3 ends. A `start` held high at that edge is accepted immediately, giving back-to-back writes with a 1-cycle `ready` pulse.
- Output changes are registered and appear 1 cycle after the tick or state change that causes them.
- `address`/`data` only need to be valid in the accept cycle.

## Structure
- Package `sccb_pkg` holds:
  - the FSM state enum;
  - `OV7670_WRITE_ID` = 8'h42;
  - the slot constants (9 bits/phase, 3 phases, 113 quarters).
- Sub-module `sccb_quarter_tick`:
  - parameterised by Q;
  - inputs `clk`, `reset`, `restart`;
  - output `tick` is a single-cycle pulse every Q cycles.

## Test plan
All directed tests use CLK_FREQ=800 and SCCB_FREQ=100, giving Q=2.
1. Reset asserted → `ready`=1, `sioc_oe`=0, `siod_oe`=0. `start` pulses while in reset are ignored.
2. Accept address 0x12, data 0x80, with a bus monitor sampling SIOD on SIOC rising edges:
   - monitor decodes bytes 0x42, 0x12, 0x80;
   - 9th bits are released;
   - `ready` is low for 226 cycles.
3. Bus protocol checks on the same write:
   - START is SIOD falling while SIOC high;
   - STOP is SIOD rising while SIOC high;
   - no other SIOD edge occurs while SIOC is high.
4. `start` pulsed at cycle 50 of a busy transaction with address 0x3A → ignored; only the original write appears on the bus.
5. `start` held continuously with address 0x11 then 0x0C:
   - two writes occur back-to-back;
   - `ready` is high for exactly 1 cycle between them.
6. `reset` asserted during phase 2, bit 3:
   - next cycle: lines released and `ready`=1;
   - a fresh write of 0x40/0xD0 afterwards decodes correctly.

Source files
------------

// File: rtl/sccb_pkg.sv
// SCCB write master: FSM state type and the slot/phase constants shared by the block.
// Pure definitions, no logic.
// The camera write ID and transaction shape live here so the top and its users agree.
package sccb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START1,
      ST_START2,
      ST_BIT_LO,
      ST_BIT_HI,
      ST_STOP1,
      ST_STOP2,
      ST_STOP3
   } sccb_state_e;

   localparam logic [7:0] OV7670_WRITE_ID = 8'h42;
   localparam int BITS_PER_PHASE = 9;
   localparam int NUM_PHASES     = 3;
   localparam int TXN_QUARTERS   = 2 + NUM_PHASES * BITS_PER_PHASE * 4 + 3;

endpackage

// File: rtl/sccb_master_if.sv
// Request/handshake and open-drain pull-low enables between sequencer, master and pads.
// Wiring only, no latency.
// ready is the only flow control: a request is taken when start and ready are both high.
interface sccb_master_if;
   logic       start;
   logic [7:0] address;
   logic [7:0] data;
   logic       ready;
   logic       sioc_oe;
   logic       siod_oe;

   modport master (
      input  start, address, data,
      output ready, sioc_oe, siod_oe
   );

   modport slave (
      output start, address, data,
      input  ready, sioc_oe, siod_oe
   );
endinterface

// File: rtl/sccb_quarter_tick.sv
// Quarter-period strobe generator: single-cycle tick every Q clocks.
// First tick Q cycles after restart; free-running otherwise.
// No backpressure; restart simply re-phases the count.
module sccb_quarter_tick #(
   parameter int Q = 62
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);
   localparam int CW = (Q > 1) ? $clog2(Q) : 1;
   localparam logic [CW-1:0] LAST = CW'(Q - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // next count: wrap after Q-1, forced back to zero when a transaction starts
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (restart || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   // count register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);
endmodule

// File: rtl/sccb_master.sv
// SCCB (OV7670) 3-phase write master: start, 27 bit slots (ID, address, data), stop.
// Latency: ready drops the cycle after accept and rises again 113 quarter periods later.
// Backpressure: start is honoured only while ready=1; requests while busy are dropped.
module sccb_master
   import sccb_pkg::*;
#(
   parameter int         CLK_FREQ    = 25000000,
   parameter int         SCCB_FREQ   = 100000,
   parameter logic [7:0] CAMERA_ADDR = OV7670_WRITE_ID
) (
   input logic           clk,
   input logic           reset,
   sccb_master_if.master bus
);
   localparam int Q = CLK_FREQ / (4 * SCCB_FREQ);
   localparam logic [4:0] LAST_BIT   = 5'(BITS_PER_PHASE - 1);
   localparam logic [1:0] LAST_PHASE = 2'(NUM_PHASES - 1);

   if (Q < 2) begin : g_bad_q
      $error("sccb_master: CLK_FREQ/(4*SCCB_FREQ) must be at least 2");
   end

   sccb_state_e state_q, state_d;
   logic        half_q, half_d;      // second quarter of a 2Q bit half
   logic [4:0]  bit_q, bit_d;
   logic [1:0]  phase_q, phase_d;
   logic [23:0] shreg_q, shreg_d;
   logic        ready_q, ready_d;
   logic        sioc_oe_q, sioc_oe_d;
   logic        siod_oe_q, siod_oe_d;
   logic        restart;
   logic        tick;

   sccb_quarter_tick #(.Q(Q)) u_tick (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .tick    (tick)
   );

   // next state, slot sequencing, and line levels derived from the next state
   always_comb begin
      state_d = state_q;
      half_d  = half_q;
      bit_d   = bit_q;
      phase_d = phase_q;
      shreg_d = shreg_q;
      restart = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start && ready_q) begin
               state_d = ST_START1;
               restart = 1'b1;
               shreg_d = {CAMERA_ADDR, bus.address, bus.data};
               half_d  = 1'b0;
               bit_d   = '0;
               phase_d = '0;
            end
         end
         ST_START1: if (tick) state_d = ST_START2;
         ST_START2: if (tick) state_d = ST_BIT_LO;
         ST_BIT_LO: begin
            if (tick) begin
               half_d = ~half_q;
               if (half_q) state_d = ST_BIT_HI;
            end
         end
         ST_BIT_HI: begin
            if (tick) begin
               half_d = ~half_q;
               if (half_q) begin
                  state_d = ST_BIT_LO;
                  if (bit_q == LAST_BIT) begin
                     bit_d = '0;
                     if (phase_q == LAST_PHASE) begin
                        state_d = ST_STOP1;
                     end else begin
                        phase_d = phase_q + 2'd1;
                     end
                  end else begin
                     bit_d   = bit_q + 5'd1;
                     shreg_d = {shreg_q[22:0], 1'b0};
                  end
               end
            end
         end
         ST_STOP1: if (tick) state_d = ST_STOP2;
         ST_STOP2: if (tick) state_d = ST_STOP3;
         ST_STOP3: if (tick) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // pull-low enables for the state being entered; 9th bit of a phase is released
      sioc_oe_d = 1'b0;
      siod_oe_d = 1'b0;
      case (state_d)
         ST_START1: siod_oe_d = 1'b1;
         ST_START2: begin
            sioc_oe_d = 1'b1;
            siod_oe_d = 1'b1;
         end
         ST_BIT_LO: begin
            sioc_oe_d = 1'b1;
            siod_oe_d = (bit_d == LAST_BIT) ? 1'b0 : ~shreg_d[23];
         end
         ST_BIT_HI: siod_oe_d = (bit_d == LAST_BIT) ? 1'b0 : ~shreg_d[23];
         ST_STOP1: begin
            sioc_oe_d = 1'b1;
            siod_oe_d = 1'b1;
         end
         ST_STOP2: siod_oe_d = 1'b1;
         default: begin
            sioc_oe_d = 1'b0;
            siod_oe_d = 1'b0;
         end
      endcase

      ready_d = (state_d == ST_IDLE);
   end

   // state and registered outputs; reset releases both lines without a stop
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         half_q    <= 1'b0;
         bit_q     <= '0;
         phase_q   <= '0;
         shreg_q   <= '0;
         ready_q   <= 1'b1;
         sioc_oe_q <= 1'b0;
         siod_oe_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         half_q    <= half_d;
         bit_q     <= bit_d;
         phase_q   <= phase_d;
         shreg_q   <= shreg_d;
         ready_q   <= ready_d;
         sioc_oe_q <= sioc_oe_d;
         siod_oe_q <= siod_oe_d;
      end
   end

   assign bus.ready   = ready_q;
   assign bus.sioc_oe = sioc_oe_q;
   assign bus.siod_oe = siod_oe_q;
endmodule

// File: tb/tb_sccb_master.sv
// Bench for sccb_master at Q=2: line-level reference waveform, SIOC-edge bit monitor,
// START/STOP protocol watch, busy-ignore, back-to-back and mid-transaction reset.
module tb_sccb_master;
   localparam int CLK_FREQ  = 800;
   localparam int SCCB_FREQ = 100;
   localparam int Q         = CLK_FREQ / (4 * SCCB_FREQ);
   localparam int TXN_CYC   = 113 * Q;
   localparam int LIMIT     = TXN_CYC + 20;

   logic clk = 1'b0;
   logic reset;

   sccb_master_if bus();

   sccb_master #(
      .CLK_FREQ    (CLK_FREQ),
      .SCCB_FREQ   (SCCB_FREQ),
      .CAMERA_ADDR (8'h42)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // open-drain line levels as the camera sees them
   wire scl = ~bus.sioc_oe;
   wire sda = ~bus.siod_oe;

   // bus monitor: SDA at each SCL rise, and any SDA edge while SCL stays high
   logic mon_bits[$];
   logic hi_edges[$];
   logic prev_scl = 1'b1;
   logic prev_sda = 1'b1;

   always @(posedge clk) begin
      #2;
      if (scl === 1'b1 && prev_scl === 1'b0) mon_bits.push_back(sda);
      if (scl === 1'b1 && prev_scl === 1'b1 && sda !== prev_sda) hi_edges.push_back(sda);
      prev_scl = scl;
      prev_sda = sda;
   end

   task automatic clear_mon();
      mon_bits.delete();
      hi_edges.delete();
   endtask

   // Called at the falling edge of the first cycle after accept. Follows the write until
   // ready returns, checking every cycle against the ideal SCL/SDA waveform, then checks
   // decoded bytes and framing. inject_at/reset_at (cycle index, <=0 = off) add stimulus.
   task automatic watch_txn(input logic [7:0] a, input logic [7:0] d,
                            input int inject_at, input int reset_at, input string tag);
      logic [1:0] w[$];
      logic [7:0] exp_b[3];
      logic [7:0] got;
      logic [2:0] ninth;
      logic [1:0] pe;
      logic       v;
      int k, bad, first_bad, nb, ne;

      exp_b[0] = 8'h42;
      exp_b[1] = a;
      exp_b[2] = d;
      // ideal line levels per quarter period: {scl, sda}
      w.push_back(2'b10);
      w.push_back(2'b00);
      for (int ph = 0; ph < 3; ph++) begin
         for (int b = 0; b < 9; b++) begin
            v = (b < 8) ? exp_b[ph][7-b] : 1'b1;
            repeat (2) w.push_back({1'b0, v});
            repeat (2) w.push_back({1'b1, v});
         end
      end
      w.push_back(2'b00);
      w.push_back(2'b10);
      w.push_back(2'b11);

      bad = 0;
      first_bad = -1;
      k = 1;
      while (bus.ready !== 1'b1 && k <= LIMIT) begin
         if (reset_at > 0 && k == reset_at) begin
            reset = 1'b1;
            @(negedge clk);
            n_vec++;
            if ({bus.ready, bus.sioc_oe, bus.siod_oe} !== 3'b100) begin
               n_err++;
               $display("FAIL %s reset_release: ready,sioc_oe,siod_oe=%b expected 100", tag,
                        {bus.ready, bus.sioc_oe, bus.siod_oe});
            end
            reset = 1'b0;
            return;
         end
         if (inject_at > 0 && k == inject_at) begin
            bus.start   = 1'b1;
            bus.address = 8'h3A;
         end else if (inject_at > 0 && k == inject_at + 1) begin
            bus.start = 1'b0;
         end
         if (k > TXN_CYC || {scl, sda} !== w[(k-1)/Q]) begin
            bad++;
            if (first_bad < 0) first_bad = k;
         end
         k++;
         @(negedge clk);
      end

      n_vec++;
      if (k - 1 !== TXN_CYC) begin
         n_err++;
         $display("FAIL %s ready_low: %0d cycles, expected %0d", tag, k - 1, TXN_CYC);
      end
      n_vec++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL %s waveform: %0d bad cycles (first at %0d), expected 0", tag, bad, first_bad);
      end
      n_vec++;
      if ({scl, sda} !== 2'b11) begin
         n_err++;
         $display("FAIL %s idle_lines: scl,sda=%b expected 11", tag, {scl, sda});
      end

      // 27 data/9th-bit clocks plus the SCL release that precedes STOP
      nb = mon_bits.size();
      n_vec++;
      if (nb !== 28) begin
         n_err++;
         $display("FAIL %s scl_rises: %0d, expected 28", tag, nb);
      end
      for (int ph = 0; ph < 3; ph++) begin
         got = 'x;
         for (int i = 0; i < 8; i++) if (ph * 9 + i < nb) got[7-i] = mon_bits[ph*9+i];
         n_vec++;
         if (got !== exp_b[ph]) begin
            n_err++;
            $display("FAIL %s byte%0d: got %h expected %h", tag, ph, got, exp_b[ph]);
         end
      end
      ninth = 'x;
      for (int ph = 0; ph < 3; ph++) if (ph * 9 + 8 < nb) ninth[2-ph] = mon_bits[ph*9+8];
      n_vec++;
      if (ninth !== 3'b111) begin
         n_err++;
         $display("FAIL %s ninth_bits: %b expected 111", tag, ninth);
      end

      // only START (fall) then STOP (rise) may move SDA while SCL is high
      ne = hi_edges.size();
      pe = (ne == 2) ? {hi_edges[0], hi_edges[1]} : 2'bxx;
      n_vec++;
      if (ne !== 2 || pe !== 2'b01) begin
         n_err++;
         $display("FAIL %s start_stop: %0d high-SCL SDA edges (levels %b), expected 2 (01)", tag, ne, pe);
      end
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                           input int inject_at, input int reset_at, input string tag);
      clear_mon();
      bus.start   = 1'b1;
      bus.address = a;
      bus.data    = d;
      @(negedge clk);
      bus.start   = 1'b0;
      bus.address = 8'($urandom);
      bus.data    = 8'($urandom);
      watch_txn(a, d, inject_at, reset_at, tag);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.start   = 1'($urandom);
         bus.address = 8'($urandom);
         bus.data    = 8'($urandom);
         @(negedge clk);
         n_vec++;
         if ({bus.ready, bus.sioc_oe, bus.siod_oe} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_hold: ready,sioc_oe,siod_oe=%b expected 100", {bus.ready, bus.sioc_oe, bus.siod_oe});
         end
      end
      reset = 1'b0;
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_vec++;
         if ({bus.ready, bus.sioc_oe, bus.siod_oe} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_after: ready,sioc_oe,siod_oe=%b expected 100", {bus.ready, bus.sioc_oe, bus.siod_oe});
         end
      end
   endtask

   task automatic test_basic_write();
      do_write(8'h12, 8'h80, 0, 0, "basic");
   endtask

   task automatic test_busy_ignore();
      int hi;
      do_write(8'h55, 8'($urandom), 50, 0, "busy");
      hi = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.ready === 1'b1) hi++;
         @(negedge clk);
      end
      n_vec++;
      if (hi !== 5) begin
         n_err++;
         $display("FAIL busy_no_queue: ready high %0d of 5 idle cycles, expected 5", hi);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d1, d2;
      d1 = 8'($urandom);
      d2 = 8'($urandom);
      clear_mon();
      bus.start   = 1'b1;
      bus.address = 8'h11;
      bus.data    = d1;
      @(negedge clk);
      bus.address = 8'h0C;
      bus.data    = d2;
      watch_txn(8'h11, d1, 0, 0, "b2b_first");
      clear_mon();
      @(negedge clk);
      n_vec++;
      if (bus.ready !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_ready_pulse: ready=%b one cycle after rising, expected 0", bus.ready);
      end
      bus.start = 1'b0;
      watch_txn(8'h0C, d2, 0, 0, "b2b_second");
   endtask

   task automatic test_reset_mid();
      // phase 2, bit 3 spans quarters 86..89 after accept
      do_write(8'($urandom), 8'($urandom), 0, 87 * Q + 1, "mid_reset");
      repeat (3) @(negedge clk);
      do_write(8'h40, 8'hD0, 0, 0, "after_reset");
   endtask

   task automatic test_random();
      for (int t = 0; t < 6; t++) begin
         repeat ($urandom_range(0, 5)) @(negedge clk);
         do_write(8'($urandom), 8'($urandom), 0, 0, "random");
      end
   endtask

   initial begin
      reset       = 1'b1;
      bus.start   = 1'b0;
      bus.address = 8'h00;
      bus.data    = 8'h00;
      test_reset();
      test_basic_write();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
